// File: rtl/multdiv_result_checker.sv
// rtl/multdiv_result_checker.sv - serial golden-model checker for multiplier/divider results
//
// Captures one operation (operands plus the unit's result, remainder and
// exception), recomputes |multiplicand| * |B| with a 16-step shift-add
// datapath and reports a registered verdict with a one-cycle done pulse.
//
// Ports:
//   clock, reset_n     clock and asynchronous active-low reset
//   check_valid/ready  capture handshake; ready is high only while idle
//   ctrl_op            0 = multiply check, 1 = divide check
//   data_operandA/B    signed operands (32 / 16 bits)
//   dut_result         product low word or quotient under test
//   dut_remainder      divider magnitude remainder (divide only)
//   dut_exception      multiplier overflow flag (multiply only)
//   ctrl_clear         synchronous clear of fault_count
//   done               one-cycle verdict strobe
//   fault, fault_code  verdict and cause bits, held until the next done
//   expected_result    golden low word, held until the next done
//   fault_count        saturating count of faulting verdicts
module multdiv_result_checker #(
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               check_valid,
    output logic               check_ready,
    input  logic               ctrl_op,
    input  logic [31:0]        data_operandA,
    input  logic [15:0]        data_operandB,
    input  logic [31:0]        dut_result,
    input  logic [31:0]        dut_remainder,
    input  logic               dut_exception,
    input  logic               ctrl_clear,
    output logic               done,
    output logic               fault,
    output logic [2:0]         fault_code,
    output logic [31:0]        expected_result,
    output logic [COUNT_W-1:0] fault_count
);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    state_t      state;
    logic        op_q;
    logic [31:0] a_q;
    logic [15:0] b_q;
    logic [31:0] res_q;
    logic [31:0] rem_q;
    logic        exc_q;
    logic [47:0] mcand;
    logic [15:0] mplier;
    logic [47:0] acc;
    logic [3:0]  iter;

    // Magnitudes of live inputs, used only at capture time
    logic [31:0] abs_a_in;
    logic [15:0] abs_b_in;
    logic [31:0] abs_res_in;
    assign abs_a_in   = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    assign abs_b_in   = data_operandB[15] ? (~data_operandB + 16'd1) : data_operandB;
    assign abs_res_in = dut_result[31]    ? (~dut_result + 32'd1)    : dut_result;

    // Magnitudes of captured operands for the verdict
    logic [31:0] abs_a_q;
    logic [15:0] abs_b_q;
    assign abs_a_q = a_q[31] ? (~a_q + 32'd1) : a_q;
    assign abs_b_q = b_q[15] ? (~b_q + 16'd1) : b_q;

    logic        neg_q;
    logic [47:0] p_signed;
    logic        mul_exc;
    logic        div_b0;
    logic        div_b1;
    logic [2:0]  code_next;
    logic [31:0] exp_next;
    logic        fault_next;

    always_comb begin
        neg_q      = a_q[31] ^ b_q[15];
        p_signed   = neg_q ? (~acc + 48'd1) : acc;
        // Overflow when the 48-bit product is not a sign extension of bit 31
        mul_exc    = (p_signed[47:32] != {16{p_signed[31]}});
        // Divide: |q|*|B| + rem must rebuild |A|, and a nonzero quotient
        // must carry the sign implied by the operands
        div_b0     = ((acc + {16'b0, rem_q}) != {16'b0, abs_a_q}) ||
                     ((res_q != 32'd0) && (res_q[31] != neg_q));
        div_b1     = (rem_q >= {16'b0, abs_b_q});
        code_next  = 3'b000;
        exp_next   = p_signed[31:0];
        if (!op_q) begin
            code_next = {1'b0, (exc_q != mul_exc), (res_q != p_signed[31:0])};
        end else begin
            exp_next = acc[31:0];
            if (b_q == 16'd0) begin
                code_next = 3'b100;
            end else begin
                code_next = {1'b0, div_b1, div_b0};
            end
        end
        fault_next = code_next[0] | code_next[1];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            check_ready     <= 1'b1;
            done            <= 1'b0;
            fault           <= 1'b0;
            fault_code      <= 3'b000;
            expected_result <= 32'd0;
            fault_count     <= '0;
            op_q            <= 1'b0;
            a_q             <= 32'd0;
            b_q             <= 16'd0;
            res_q           <= 32'd0;
            rem_q           <= 32'd0;
            exc_q           <= 1'b0;
            mcand           <= 48'd0;
            mplier          <= 16'd0;
            acc             <= 48'd0;
            iter            <= 4'd0;
        end else begin
            // Clear wins over an increment landing on the same edge
            if (ctrl_clear) begin
                fault_count <= '0;
            end else if (state == CHECK && fault_next && !(&fault_count)) begin
                fault_count <= fault_count + {{(COUNT_W-1){1'b0}}, 1'b1};
            end

            case (state)
                IDLE: begin
                    if (check_valid) begin
                        op_q        <= ctrl_op;
                        a_q         <= data_operandA;
                        b_q         <= data_operandB;
                        res_q       <= dut_result;
                        rem_q       <= dut_remainder;
                        exc_q       <= dut_exception;
                        mcand       <= {16'b0, (ctrl_op ? abs_res_in : abs_a_in)};
                        mplier      <= abs_b_in;
                        acc         <= 48'd0;
                        iter        <= 4'd0;
                        check_ready <= 1'b0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= {mcand[46:0], 1'b0};
                    mplier <= {1'b0, mplier[15:1]};
                    iter   <= iter + 4'd1;
                    if (iter == 4'd15) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    fault           <= fault_next;
                    fault_code      <= code_next;
                    expected_result <= exp_next;
                    done            <= 1'b1;
                    state           <= DONE;
                end
                DONE: begin
                    done        <= 1'b0;
                    check_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_result_checker.sv
// tb/tb_multdiv_result_checker.sv - scoreboard bench for multdiv_result_checker
module tb_multdiv_result_checker;

    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          check_valid;
    logic          check_ready;
    logic          ctrl_op;
    logic [31:0]   data_operandA;
    logic [15:0]   data_operandB;
    logic [31:0]   dut_result;
    logic [31:0]   dut_remainder;
    logic          dut_exception;
    logic          ctrl_clear;
    logic          done;
    logic          fault;
    logic [2:0]    fault_code;
    logic [31:0]   expected_result;
    logic [CW-1:0] fault_count;

    multdiv_result_checker #(.COUNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n),
        .check_valid(check_valid), .check_ready(check_ready),
        .ctrl_op(ctrl_op), .data_operandA(data_operandA), .data_operandB(data_operandB),
        .dut_result(dut_result), .dut_remainder(dut_remainder), .dut_exception(dut_exception),
        .ctrl_clear(ctrl_clear), .done(done), .fault(fault), .fault_code(fault_code),
        .expected_result(expected_result), .fault_count(fault_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic        flt;
        logic [2:0]  code;
        logic [31:0] exp;
        int          cnt;
        int          cyc;
    } item_t;

    item_t sb[$];
    item_t it_m;
    int checks = 0;
    int errors = 0;
    int cnt_m  = 0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference model: plain signed arithmetic on 64-bit integers
    task automatic model(input bit op, input logic [31:0] a, input logic [15:0] b,
                         input logic [31:0] res, input logic [31:0] rem, input bit exc,
                         input bit clr, output item_t it);
        longint sa, sbv, prod, ma, mb, mq, p, sq;
        bit b0, b1;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        it.code = 3'b000;
        if (!op) begin
            prod = sa * sbv;
            it.exp = prod[31:0];
            b0 = (res != prod[31:0]);
            b1 = (exc != (longint'($signed(prod[31:0])) != prod));
            it.code = {1'b0, b1, b0};
        end else if (sbv == 0) begin
            it.exp  = 32'd0;
            it.code = 3'b100;
        end else begin
            sq = longint'($signed(res));
            ma = (sa < 0) ? -sa : sa;
            mb = (sbv < 0) ? -sbv : sbv;
            mq = (sq < 0) ? -sq : sq;
            p  = mq * mb;
            it.exp = p[31:0];
            b0 = ((p + longint'({32'b0, rem})) != ma) ||
                 ((sq != 0) && ((sq < 0) != ((sa < 0) != (sbv < 0))));
            b1 = longint'({32'b0, rem}) >= mb;
            it.code = {1'b0, b1, b0};
        end
        it.flt = it.code[0] | it.code[1];
        if (clr) cnt_m = 0;
        else if (it.flt && cnt_m < CMAX) cnt_m = cnt_m + 1;
        it.cnt = cnt_m;
    endtask

    task automatic run_check(input bit op, input logic [31:0] a, input logic [15:0] b,
                             input logic [31:0] res, input logic [31:0] rem, input bit exc,
                             input bit hold, input bit clr);
        item_t it;
        int c0;
        int n;
        n = 0;
        @(negedge clock);
        while (!check_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!check_ready) begin
            chk("ready_timeout", check_ready, 1);
            return;
        end
        model(op, a, b, res, rem, exc, clr, it);
        c0 = cyc;
        it.cyc = c0 + 18;
        sb.push_back(it);
        ctrl_op = op; data_operandA = a; data_operandB = b;
        dut_result = res; dut_remainder = rem; dut_exception = exc;
        check_valid = 1'b1;
        @(posedge clock);
        #1;
        if (!hold) check_valid = 1'b0;
        do @(negedge clock); while (cyc < c0 + 17);
        if (clr) ctrl_clear = 1'b1;
        @(negedge clock);
        ctrl_clear = 1'b0;
        @(negedge clock);
        chk("ready_after_done", check_ready, 1);
        check_valid = 1'b0;
        chk("queue_drained", sb.size(), 0);
        sb.delete();
    endtask

    logic prev_done = 1'b0;
    always @(negedge clock) begin
        if (reset_n && done) begin
            if (prev_done || sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                it_m = sb.pop_front();
                chk("done_cycle", cyc, it_m.cyc);
                chk("fault", fault, it_m.flt);
                chk("fault_code", fault_code, it_m.code);
                chk("expected_result", expected_result, it_m.exp);
                chk("fault_count", fault_count, it_m.cnt);
                chk("ready_in_done", check_ready, 0);
            end
        end
        prev_done = reset_n && done;
    end

    task automatic rand_check();
        logic [31:0] a, res, rem;
        logic [15:0] b;
        longint sa, sbv, prod, q, ma, mb, mq;
        bit op, exc;
        op = $urandom_range(0, 1);
        a  = $urandom;
        case ($urandom_range(0, 7))
            0: b = 16'd0;
            1: b = 16'h8000;
            2: b = 16'hFFFF;
            default: b = $urandom;
        endcase
        if ($urandom_range(0, 5) == 0) a = 32'h80000000;
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        if (!op) begin
            prod = sa * sbv;
            res = prod[31:0];
            exc = (longint'($signed(prod[31:0])) != prod);
            if ($urandom_range(0, 2) == 0) res[7] = ~res[7];
            if ($urandom_range(0, 5) == 0) exc = ~exc;
            rem = $urandom;
        end else begin
            exc = $urandom_range(0, 1);
            if (sbv == 0) begin
                res = $urandom;
                rem = $urandom;
            end else begin
                q  = sa / sbv;
                ma = (sa < 0) ? -sa : sa;
                mb = (sbv < 0) ? -sbv : sbv;
                mq = (q < 0) ? -q : q;
                res = q[31:0];
                rem = 32'(ma - mq * mb);
                if ($urandom_range(0, 2) == 0) res[2] = ~res[2];
                if ($urandom_range(0, 4) == 0) rem = rem + 32'(mb);
            end
        end
        run_check(op, a, b, res, rem, exc, 1'b0, 1'b0);
    endtask

    initial begin
        int c0;
        reset_n = 1'b0; check_valid = 1'b0; ctrl_op = 1'b0; data_operandA = '0;
        data_operandB = '0; dut_result = '0; dut_remainder = '0; dut_exception = 1'b0;
        ctrl_clear = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_ready", check_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_code", fault_code, 0);
        chk("rst_expected", expected_result, 0);
        chk("rst_count", fault_count, 0);
        reset_n = 1'b1;

        run_check(0, 32'd7, 16'hFFFD, 32'hFFFFFFEB, 32'd0, 0, 0, 0);
        run_check(0, 32'd7, 16'hFFFD, 32'hFFFFFF6B, 32'd0, 0, 0, 0);
        run_check(0, 32'h40000000, 16'd4, 32'd0, 32'd0, 1, 0, 0);
        run_check(0, 32'h40000000, 16'd4, 32'd0, 32'd0, 0, 0, 0);
        run_check(1, -32'sd100, 16'd7, 32'hFFFFFFF2, 32'd2, 0, 0, 0);
        run_check(1, -32'sd100, 16'd7, 32'hFFFFFFF6, 32'd2, 0, 0, 0);
        run_check(1, -32'sd100, 16'd7, 32'hFFFFFFF2, 32'd9, 0, 0, 0);
        run_check(1, 32'd1234, 16'd0, 32'd5, 32'd3, 0, 0, 0);
        run_check(0, 32'h80000000, 16'h8000, 32'd0, 32'd0, 1, 0, 0);
        run_check(0, 32'd7, 16'hFFFD, 32'hFFFFFF6B, 32'd0, 0, 0, 1);
        for (int i = 0; i < 5; i++)
            run_check(0, 32'd7, 16'hFFFD, 32'hFFFFFF6B, 32'd0, 0, 0, 0);

        // Reset in the middle of RUN discards the check
        @(negedge clock);
        c0 = cyc;
        ctrl_op = 1'b0; data_operandA = 32'd9; data_operandB = 16'd9;
        dut_result = 32'd1; dut_exception = 1'b0; check_valid = 1'b1;
        @(posedge clock);
        #1 check_valid = 1'b0;
        do @(negedge clock); while (cyc < c0 + 8);
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", check_ready, 1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_fault", fault, 0);
        chk("mid_rst_code", fault_code, 0);
        chk("mid_rst_expected", expected_result, 0);
        chk("mid_rst_count", fault_count, 0);
        cnt_m = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("ready_after_release", check_ready, 1);
        repeat (25) @(negedge clock);

        // check_valid held high through RUN and the done cycle
        run_check(1, 32'd50, 16'hFFF9, 32'hFFFFFFF9, 32'd1, 0, 1, 0);
        repeat (25) @(negedge clock);

        for (int i = 0; i < 60; i++) rand_check();

        repeat (5) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multdiv_result_checker.md
# multdiv_result_checker

Sequential golden-model checker that sits directly downstream of the fault-injectable multiplier and divider. It captures one operation's operands together with the unit's result, remainder and exception, then recomputes the product serially with independent shift-add hardware. It flags any mismatch, so injected bit flips (result bit 7 on multiply, bit 2 on divide) and real faults are detected and counted.

## Interface
- COUNT_W, 16, width of the saturating fault counter.

- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- check_valid  in  1  capture request; accepted only when check_ready=1.
- check_ready  out  1  high only in IDLE.
- ctrl_op  in  1  0 = multiply check, 1 = divide check.
- data_operandA  in  32  signed operand A (multiplicand / dividend).
- data_operandB  in  16  signed operand B (multiplier / divisor).
- dut_result  in  32  signed product low word or signed quotient.
- dut_remainder  in  32  divider magnitude remainder; ignored for multiply.
- dut_exception  in  1  multiplier overflow flag; ignored for divide.
- ctrl_clear  in  1  synchronous clear of fault_count.
- done  out  1  one-cycle pulse when the verdict is valid.
- fault  out  1  verdict; held until the next done.
- fault_code  out  3  bit0 = result/identity error, bit1 = exception/remainder-range error, bit2 = divide-by-zero (check skipped). Held until the next done.
- expected_result  out  32  golden low word; held until the next done.
- fault_count  out  COUNT_W  number of done pulses with fault=1; saturating.

## Operation
- States: IDLE, RUN, CHECK, DONE.
  - IDLE: check_ready=1. If check_valid=1, register all inputs and go to RUN with the iteration count at 0. Otherwise stay in IDLE.
  - RUN: exactly 16 cycles, then CHECK.
  - CHECK: 1 cycle. Compare and register the verdict, then DONE.
  - DONE: done=1 for 1 cycle, then IDLE.
- check_valid is ignored outside IDLE. Captured inputs do not change during a check.
- Magnitudes are formed as unsigned values: |A| is 32-bit, so -2^31 gives 0x80000000; |B| is 16-bit, so -32768 gives 0x8000.
- RUN: unsigned shift-add over 48 bits. One multiplier bit per cycle, LSB first. Multiplier = |B|.
  - Multiply: multiplicand = |A|.
  - Divide: multiplicand = |dut_result|.
- Multiply check:
  - P = 48-bit product, negated (two's complement) if A[31]^B[15].
  - expected_result = P[31:0].
  - exp_exc = (P[47:32] != {16{P[31]}}).
  - bit0 = (dut_result != P[31:0]).
  - bit1 = (dut_exception != exp_exc).
- Divide check:
  - bit0 = (P + {16'b0, dut_remainder}) != {16'b0, |A|}, OR (dut_result != 0 AND dut_result[31] != A[31]^B[15]).
  - bit1 = (dut_remainder >= |B|).
  - expected_result = P[31:0].
- Divide with B=0: fault_code=100, fault=0, fault_count unchanged. The full RUN sequence still executes.
- fault = bit0 | bit1.
- fault_count increments in the same cycle that done rises with fault=1. It saturates at 2^COUNT_W-1.
- ctrl_clear has priority over a simultaneous increment; the count becomes 0.

## Timing
- Reset values: state IDLE, check_ready=1, done=0, fault=0, fault_code=000, expected_result=0, fault_count=0, datapath registers 0.
- Latency: accept in cycle 0 (check_valid & check_ready sampled at that edge).
  - RUN in cycles 1–16.
  - CHECK in cycle 17.
  - done=1 in cycle 18.
  - check_ready=1 again in cycle 19.
- Throughput is one check per 19 cycles.
- An input presented in the cycle done is high is not accepted; check_ready=0 in DONE.
- Reset asserted mid-check: the in-flight check is discarded and no done pulse is produced. Outputs take their reset values immediately (asynchronous). Ready resumes on the first edge after release.

## Test plan
- Multiply A=7, B=-3, dut_result=0xFFFFFFEB, exc=0 -> done in cycle 18, fault=0, code 000, expected_result=0xFFFFFFEB, count 0.
- Same with bit 7 flipped, dut_result=0xFFFFFF6B -> fault=1, code 001, count 1. Multiply A=0x40000000, B=4, result=0, exc=1 -> fault=0. Repeat with exc=0 -> code 010.
- Divide A=-100, B=7, dut_result=0xFFFFFFF2, rem=2 -> fault=0. With bit 2 flipped, dut_result=0xFFFFFFF6 -> code 001. With rem=9 -> code 011.
- Divide B=0 -> code 100, fault=0, count unchanged. Multiply A=0x80000000, B=0x8000, result=0, exc=1 -> fault=0 (P=2^46).
- Pulse reset_n low in cycle 8 of RUN -> no done pulse, all outputs at reset values, check_ready=1 after release. Hold check_valid high during RUN -> only one check performed.
- COUNT_W=2: five faulting checks -> count 1,2,3,3,3. ctrl_clear asserted in the same cycle as a faulting done -> count 0.
